salu_sgpr_wb_queue: RTL and testbench

- Parametrised successor to the SALU writeback/ready path.
- Today the SALU blocks issue until its SGPR write request drains. This block replaces that with a DEPTH-entry in-order writeback queue, a request/grant handshake to the register file arbiter, and credit-based issue_alu_ready.
- Sits between SALU stage-3 writeback and the SGPR write port / issue / tracemon.

---
 rtl/salu_sgpr_wb_queue_if.sv | 43 ++++
 rtl/salu_sgpr_wb_queue.sv | 131 +++++++++++++
 tb/tb_salu_sgpr_wb_queue.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/salu_sgpr_wb_queue_if.sv
// SALU writeback queue bus: issue credit, writeback packet, SGPR write port, tracemon, errors.
interface salu_sgpr_wb_queue_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned WFID_W = 6
);
   logic              issue_alu_select;
   logic              issue_alu_ready;
   logic              wb_valid;
   logic [WFID_W-1:0] wb_wfid;
   logic [ADDR_W-1:0] wb_dest_addr;
   logic [1:0]        wb_wr_en;
   logic [DATA_W-1:0] wb_data;
   logic [31:0]       wb_pc;
   logic              rfa2sgpr_request;
   logic              rfa2sgpr_grant;
   logic [ADDR_W-1:0] sgpr_dest_addr;
   logic [DATA_W-1:0] sgpr_dest_data;
   logic [1:0]        sgpr_dest_wr_en;
   logic              sgpr_instr_done;
   logic [WFID_W-1:0] sgpr_instr_done_wfid;
   logic [31:0]       tracemon_retire_pc;
   logic              wbq_overflow;
   logic              wbq_credit_err;

   // Environment side: issue, SALU stage 3, arbiter and SGPR file.
   modport master (
      output issue_alu_select, wb_valid, wb_wfid, wb_dest_addr, wb_wr_en, wb_data, wb_pc,
      output rfa2sgpr_grant,
      input  issue_alu_ready, rfa2sgpr_request, sgpr_dest_addr, sgpr_dest_data,
      input  sgpr_dest_wr_en, sgpr_instr_done, sgpr_instr_done_wfid, tracemon_retire_pc,
      input  wbq_overflow, wbq_credit_err
   );

   // Queue side.
   modport slave (
      input  issue_alu_select, wb_valid, wb_wfid, wb_dest_addr, wb_wr_en, wb_data, wb_pc,
      input  rfa2sgpr_grant,
      output issue_alu_ready, rfa2sgpr_request, sgpr_dest_addr, sgpr_dest_data,
      output sgpr_dest_wr_en, sgpr_instr_done, sgpr_instr_done_wfid, tracemon_retire_pc,
      output wbq_overflow, wbq_credit_err
   );
endinterface

// File: rtl/salu_sgpr_wb_queue.sv
// In-order SALU writeback queue with SGPR request/grant and credit-based issue ready.
module salu_sgpr_wb_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned PIPE_LAT = 3,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ADDR_W   = 9,
   parameter int unsigned WFID_W   = 6
) (
   input logic                clk,
   input logic                rst,
   salu_sgpr_wb_queue_if.slave bus
);
   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   // Credits cap inflight at DEPTH; the extra PIPE_LAT headroom is free margin.
   localparam int unsigned InflW = $clog2(DEPTH + PIPE_LAT + 1);
   localparam int unsigned EntW  = WFID_W + ADDR_W + 2 + DATA_W + 32;

   logic [EntW-1:0]   mem_q [DEPTH];
   logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]   count_q, count_d;
   logic [InflW-1:0]  inflight_q, inflight_d;
   logic              overflow_q, credit_err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        wr_en_q;
   logic              done_q;
   logic [WFID_W-1:0] wfid_q;
   logic [31:0]       pc_q;

   logic [EntW-1:0]   head, new_entry;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [1:0]        head_wr_en;
   logic [WFID_W-1:0] head_wfid;
   logic [31:0]       head_pc;
   logic [31:0]       occupancy;
   logic              ready, full, pop, push, overflow_evt, issue_acc;

   // Entry layout: {wfid, addr, wr_en, data, pc}
   assign new_entry  = {bus.wb_wfid, bus.wb_dest_addr, bus.wb_wr_en, bus.wb_data, bus.wb_pc};
   assign head       = mem_q[rd_ptr_q];
   assign head_pc    = head[31:0];
   assign head_data  = head[32 +: DATA_W];
   assign head_wr_en = head[32 + DATA_W +: 2];
   assign head_addr  = head[34 + DATA_W +: ADDR_W];
   assign head_wfid  = head[34 + DATA_W + ADDR_W +: WFID_W];

   assign occupancy  = 32'(count_q) + 32'(inflight_q);
   assign ready      = occupancy < DEPTH;
   assign full       = count_q == CntW'(DEPTH);
   // Entries with no write enables retire without arbitrating for the port.
   assign pop        = (count_q != '0) && ((head_wr_en == 2'b00) || bus.rfa2sgpr_grant);
   assign push       = bus.wb_valid && (!full || pop);
   assign overflow_evt = bus.wb_valid && full && !pop;
   assign issue_acc  = bus.issue_alu_select && ready;

   // Next occupancy and in-flight credit counts.
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      inflight_d = inflight_q;
      if (issue_acc && bus.wb_valid) begin
         inflight_d = inflight_q;
      end else if (issue_acc) begin
         inflight_d = inflight_q + 1'b1;
      end else if (bus.wb_valid && (inflight_q != '0)) begin
         inflight_d = inflight_q - 1'b1;
      end
   end

   // Queue storage, pointers, counters and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         inflight_q   <= '0;
         overflow_q   <= 1'b0;
         credit_err_q <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         if (overflow_evt) overflow_q <= 1'b1;
         if (bus.issue_alu_select && !ready) credit_err_q <= 1'b1;
      end
   end

   // Registered SGPR write / retire outputs, loaded from the head on pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         data_q  <= '0;
         wr_en_q <= '0;
         done_q  <= 1'b0;
         wfid_q  <= '0;
         pc_q    <= '0;
      end else if (pop) begin
         addr_q  <= head_addr;
         data_q  <= head_data;
         wr_en_q <= head_wr_en;
         done_q  <= 1'b1;
         wfid_q  <= head_wfid;
         pc_q    <= head_pc;
      end else begin
         wr_en_q <= 2'b00;
         done_q  <= 1'b0;
      end
   end

   assign bus.issue_alu_ready      = ready;
   assign bus.rfa2sgpr_request     = (count_q != '0) && (head_wr_en != 2'b00);
   assign bus.sgpr_dest_addr       = addr_q;
   assign bus.sgpr_dest_data       = data_q;
   assign bus.sgpr_dest_wr_en      = wr_en_q;
   assign bus.sgpr_instr_done      = done_q;
   assign bus.sgpr_instr_done_wfid = wfid_q;
   assign bus.tracemon_retire_pc   = pc_q;
   assign bus.wbq_overflow         = overflow_q;
   assign bus.wbq_credit_err       = credit_err_q;
endmodule

// File: tb/tb_salu_sgpr_wb_queue.sv
// Randomised bench for salu_sgpr_wb_queue against a queue-based reference model.
module tb_salu_sgpr_wb_queue;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned PIPE_LAT = 3;
   localparam int unsigned DATA_W   = 64;
   localparam int unsigned ADDR_W   = 9;
   localparam int unsigned WFID_W   = 6;

   typedef struct {
      logic [WFID_W-1:0] wfid;
      logic [ADDR_W-1:0] addr;
      logic [1:0]        wr_en;
      logic [DATA_W-1:0] data;
      logic [31:0]       pc;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   salu_sgpr_wb_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WFID_W(WFID_W)) bus ();

   salu_sgpr_wb_queue #(
      .DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WFID_W(WFID_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Reference model state: what the DUT registers should hold after the last edge.
   ent_t q[$];
   int   inflight;
   logic m_ovf, m_cerr, m_done;
   ent_t m_out;
   int   total = 0;
   int   bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic m_ready();
      return (q.size() + inflight) < DEPTH;
   endfunction

   function automatic logic m_request();
      return (q.size() != 0) && (q[0].wr_en != 2'b00);
   endfunction

   function automatic ent_t zero_ent();
      ent_t e;
      e.wfid = '0; e.addr = '0; e.wr_en = '0; e.data = '0; e.pc = '0;
      return e;
   endfunction

   function automatic ent_t rand_ent(input logic allow_retire_only);
      ent_t e;
      e.wfid  = WFID_W'($urandom);
      e.addr  = ADDR_W'($urandom);
      e.wr_en = (allow_retire_only && $urandom_range(0, 3) == 0) ? 2'b00
                                                                 : 2'($urandom_range(1, 3));
      e.data  = {$urandom, $urandom};
      e.pc    = $urandom;
      return e;
   endfunction

   task automatic model_reset();
      q.delete();
      inflight = 0;
      m_ovf    = 1'b0;
      m_cerr   = 1'b0;
      m_done   = 1'b0;
      m_out    = zero_ent();
   endtask

   task automatic check_all();
      check("ready",    64'(bus.issue_alu_ready),      64'(m_ready()));
      check("request",  64'(bus.rfa2sgpr_request),     64'(m_request()));
      check("wr_en",    64'(bus.sgpr_dest_wr_en),      64'(m_done ? m_out.wr_en : 2'b00));
      check("done",     64'(bus.sgpr_instr_done),      64'(m_done));
      check("addr",     64'(bus.sgpr_dest_addr),       64'(m_out.addr));
      check("data",     64'(bus.sgpr_dest_data),       64'(m_out.data));
      check("wfid",     64'(bus.sgpr_instr_done_wfid), 64'(m_out.wfid));
      check("pc",       64'(bus.tracemon_retire_pc),   64'(m_out.pc));
      check("overflow", 64'(bus.wbq_overflow),         64'(m_ovf));
      check("cred_err", 64'(bus.wbq_credit_err),       64'(m_cerr));
   endtask

   task automatic drive_idle();
      bus.issue_alu_select = 1'b0;
      bus.wb_valid         = 1'b0;
      bus.wb_wfid          = '0;
      bus.wb_dest_addr     = '0;
      bus.wb_wr_en         = '0;
      bus.wb_data          = '0;
      bus.wb_pc            = '0;
      bus.rfa2sgpr_grant   = 1'b0;
   endtask

   // One clock: drive at the negedge, advance the model, check at the next negedge.
   task automatic cycle(input logic sel, input logic wbv, input ent_t e, input logic gnt);
      logic rdy, pop, inc;
      int   sz;
      bus.issue_alu_select = sel;
      bus.wb_valid         = wbv;
      bus.wb_wfid          = e.wfid;
      bus.wb_dest_addr     = e.addr;
      bus.wb_wr_en         = e.wr_en;
      bus.wb_data          = e.data;
      bus.wb_pc            = e.pc;
      bus.rfa2sgpr_grant   = gnt;

      rdy = m_ready();
      sz  = q.size();
      pop = (sz != 0) && ((q[0].wr_en == 2'b00) || gnt);
      inc = sel && rdy;
      if (sel && !rdy) m_cerr = 1'b1;
      if (inc && wbv) begin
         // balanced: unchanged
      end else if (inc) begin
         inflight++;
      end else if (wbv && inflight > 0) begin
         inflight--;
      end
      if (pop) begin
         m_out  = q.pop_front();
         m_done = 1'b1;
      end else begin
         m_done = 1'b0;
      end
      if (wbv) begin
         if (sz < DEPTH || pop) q.push_back(e);
         else m_ovf = 1'b1;
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic random_phase(input int n);
      for (int i = 0; i < n; i++) begin
         logic gnt;
         // Alternate grant-starved and grant-rich stretches to fill and drain the queue.
         gnt = ((i / 32) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4), rand_ent(1'b1), gnt);
      end
   endtask

   initial begin
      ent_t e;
      rst = 1'b1;
      drive_idle();
      model_reset();
      @(negedge clk);
      check_all();
      rst = 1'b0;
      @(negedge clk);
      check_all();

      // Single write with grant tied high; writeback PIPE_LAT cycles after issue.
      e.wfid = 6'd5; e.addr = 9'h012; e.wr_en = 2'b11;
      e.data = 64'hDEAD_BEEF_0000_0001; e.pc = 32'h100;
      cycle(1'b1, 1'b0, zero_ent(), 1'b1);
      cycle(1'b0, 1'b0, zero_ent(), 1'b1);
      cycle(1'b0, 1'b0, zero_ent(), 1'b1);
      cycle(1'b0, 1'b1, e, 1'b1);
      check("single_req", 64'(bus.rfa2sgpr_request), 64'd1);
      cycle(1'b0, 1'b0, zero_ent(), 1'b1);
      check("single_done", 64'(bus.sgpr_instr_done), 64'd1);
      check("single_addr", 64'(bus.sgpr_dest_addr), 64'h012);
      cycle(1'b0, 1'b0, zero_ent(), 1'b1);

      // Backpressure: four credits, a fifth select is a credit error.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, zero_ent(), 1'b0);
      check("bp_ready0", 64'(bus.issue_alu_ready), 64'd0);
      cycle(1'b1, 1'b0, zero_ent(), 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, rand_ent(1'b0), 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, zero_ent(), 1'b1);

      // Retire-only entry pops without grant.
      e = rand_ent(1'b0);
      e.wr_en = 2'b00;
      cycle(1'b0, 1'b1, e, 1'b0);
      check("ro_req", 64'(bus.rfa2sgpr_request), 64'd0);
      cycle(1'b0, 1'b0, zero_ent(), 1'b0);
      cycle(1'b0, 1'b0, zero_ent(), 1'b0);

      // Full queue: push+grant is legal, push without grant overflows.
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, rand_ent(1'b0), 1'b0);
      cycle(1'b0, 1'b1, rand_ent(1'b0), 1'b1);
      check("full_no_ovf", 64'(bus.wbq_overflow), 64'd0);
      cycle(1'b0, 1'b1, rand_ent(1'b0), 1'b0);
      check("full_ovf", 64'(bus.wbq_overflow), 64'd1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, zero_ent(), 1'b1);

      random_phase(400);

      // Asynchronous reset with three entries queued.
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, zero_ent(), 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, rand_ent(1'b0), 1'b0);
      drive_idle();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      check_all();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, zero_ent(), 1'b1);

      random_phase(300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
